// File: rtl/memoria_dados_ctrl.sv
// Data memory stage: word-organised RAM with byte/halfword/word load/store,
// little-endian lanes, sign/zero extension of loads and a configurable number
// of wait states before each access completes.
module memoria_dados_ctrl #(
  parameter int PALAVRAS = 256,
  parameter int LATENCIA = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        escrita,
  input  logic [1:0]  tamanho,
  input  logic        sinal,
  input  logic [31:0] endereco,
  input  logic [31:0] dado_escrita,
  output logic        ocupado,
  output logic        pronto,
  output logic [31:0] dado_lido,
  output logic        erro
);

  localparam int IDX_W = (PALAVRAS > 1) ? $clog2(PALAVRAS) : 1;
  localparam int AW    = IDX_W + 2;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    ESPERA = 2'd1,
    ACESSO = 2'd2,
    ERRO   = 2'd3
  } estado_t;

  estado_t           estado;
  logic [3:0]        contador;

  // Request fields captured when a request is accepted
  logic              escrita_q;
  logic [1:0]        tamanho_q;
  logic              sinal_q;
  logic [AW-1:0]     endereco_q;
  logic [31:0]       dado_q;

  logic [31:0]       mem [PALAVRAS];

  // Fields of the access being resolved this cycle: straight from the inputs
  // when a zero-latency access completes in the accepting cycle, otherwise
  // from the captured copy.
  logic              cur_escrita;
  logic [1:0]        cur_tamanho;
  logic              cur_sinal;
  logic [AW-1:0]     cur_endereco;
  logic [IDX_W-1:0]  cur_idx;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       palavra_lida;
  logic              valido_entrada;
  logic              fim_espera;
  logic              inicio_leitura;

  // Alignment, size and range check of an incoming request
  function automatic logic pedido_valido(input logic [1:0] tam, input logic [31:0] ender);
    logic ok;
    case (tam)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~ender[0];
      2'b10:   ok = (ender[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    if ({2'b00, ender[31:2]} >= 32'(PALAVRAS)) ok = 1'b0;
    return ok;
  endfunction

  // Select the addressed lane of a word and extend it to 32 bits
  function automatic logic [31:0] extrai_leitura(input logic [31:0] palavra, input logic [1:0] tam,
                                                 input logic sg, input logic [1:0] sel);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic        [31:0] r;
    b   = palavra[8*sel +: 8];
    h   = palavra[16*sel[1] +: 16];
    b_s = signed'(b);
    h_s = signed'(h);
    case (tam)
      2'b00:   r = sg ? 32'(b_s) : {24'd0, b};
      2'b01:   r = sg ? 32'(h_s) : {16'd0, h};
      default: r = palavra;
    endcase
    return r;
  endfunction

  // Merge store data into the addressed lanes, leaving the other lanes intact
  function automatic logic [31:0] mescla_escrita(input logic [31:0] antiga, input logic [31:0] dado,
                                                 input logic [1:0] tam, input logic [1:0] sel);
    logic [31:0] r;
    r = antiga;
    case (tam)
      2'b00:   r[8*sel +: 8]     = dado[7:0];
      2'b01:   r[16*sel[1] +: 16] = dado[15:0];
      default: r = dado;
    endcase
    return r;
  endfunction

  // Choose between live inputs and captured fields for the read path
  always_comb begin
    cur_escrita  = escrita_q;
    cur_tamanho  = tamanho_q;
    cur_sinal    = sinal_q;
    cur_endereco = endereco_q;
    if (estado == OCIOSO) begin
      cur_escrita  = escrita;
      cur_tamanho  = tamanho;
      cur_sinal    = sinal;
      cur_endereco = endereco[AW-1:0];
    end
  end

  assign cur_idx        = cur_endereco[AW-1:2];
  assign idx_q          = endereco_q[AW-1:2];
  assign palavra_lida   = mem[cur_idx];
  assign valido_entrada = pedido_valido(tamanho, endereco);
  assign fim_espera     = (estado == ESPERA) && (contador == 4'(LATENCIA));
  assign inicio_leitura = ((estado == OCIOSO) && req && valido_entrada && (LATENCIA == 0) && !escrita) ||
                          (fim_espera && !escrita_q);

  // Control FSM with registered handshake outputs and load result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado    <= OCIOSO;
      contador  <= 4'd0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      dado_lido <= 32'd0;
    end else begin
      pronto <= 1'b0;
      erro   <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (req) begin
            if (!valido_entrada) begin
              estado  <= ERRO;
              pronto  <= 1'b1;
              erro    <= 1'b1;
              ocupado <= 1'b0;
            end else if (LATENCIA == 0) begin
              estado  <= ACESSO;
              pronto  <= 1'b1;
              ocupado <= 1'b0;
            end else begin
              estado   <= ESPERA;
              contador <= 4'd1;
              ocupado  <= 1'b1;
            end
          end
        end
        ESPERA: begin
          if (fim_espera) begin
            estado   <= ACESSO;
            contador <= 4'd0;
            ocupado  <= 1'b0;
            pronto   <= 1'b1;
          end else begin
            contador <= contador + 4'd1;
          end
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
      if (inicio_leitura) begin
        dado_lido <= extrai_leitura(palavra_lida, cur_tamanho, cur_sinal, cur_endereco[1:0]);
      end
    end
  end

  // Capture the request fields whenever a request is accepted
  always_ff @(posedge clock) begin
    if ((estado == OCIOSO) && req) begin
      escrita_q  <= escrita;
      tamanho_q  <= tamanho;
      sinal_q    <= sinal;
      endereco_q <= endereco[AW-1:0];
      dado_q     <= dado_escrita;
    end
  end

  // Commit a store at the end of its completion cycle; an aborted access never gets here
  always_ff @(posedge clock) begin
    if ((estado == ACESSO) && escrita_q) begin
      mem[idx_q] <= mescla_escrita(mem[idx_q], dado_q, tamanho_q, endereco_q[1:0]);
    end
  end

endmodule

// File: tb/tb_memoria_dados_ctrl.sv
// Bench for memoria_dados_ctrl: one instance with two wait states, one with
// none, both checked against a byte-addressed reference memory.
module tb_memoria_dados_ctrl;

  logic        clock;
  logic        reset;
  logic        req_a, req_b;
  logic        escrita;
  logic [1:0]  tamanho;
  logic        sinal;
  logic [31:0] endereco;
  logic [31:0] dado_escrita;
  logic        ocupado_a, pronto_a, erro_a;
  logic        ocupado_b, pronto_b, erro_b;
  logic [31:0] lido_a, lido_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_mem [2][0:1023];
  logic [31:0] last_rd [2];

  memoria_dados_ctrl #(.PALAVRAS(256), .LATENCIA(2)) dut_a (
    .clock(clock), .reset(reset), .req(req_a), .escrita(escrita), .tamanho(tamanho),
    .sinal(sinal), .endereco(endereco), .dado_escrita(dado_escrita),
    .ocupado(ocupado_a), .pronto(pronto_a), .dado_lido(lido_a), .erro(erro_a));

  memoria_dados_ctrl #(.PALAVRAS(256), .LATENCIA(0)) dut_b (
    .clock(clock), .reset(reset), .req(req_b), .escrita(escrita), .tamanho(tamanho),
    .sinal(sinal), .endereco(endereco), .dado_escrita(dado_escrita),
    .ocupado(ocupado_b), .pronto(pronto_b), .dado_lido(lido_b), .erro(erro_b));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic model_valid(input logic [1:0] t, input logic [31:0] a);
    return (t != 2'b11) && !(t == 2'b01 && a[0]) && !(t == 2'b10 && a[1:0] != 2'b00) && (a / 4 < 256);
  endfunction

  function automatic logic [31:0] model_load(input int s, input logic [1:0] t, input logic sg, input logic [31:0] a);
    int    i;
    longint v;
    i = int'(a[9:0]);
    case (t)
      2'b00: begin
        v = longint'(ref_mem[s][i]);
        if (sg && v >= 128) v = v - 256;
      end
      2'b01: begin
        v = longint'(ref_mem[s][i]) + 256 * longint'(ref_mem[s][i+1]);
        if (sg && v >= 32768) v = v - 65536;
      end
      default: v = longint'(ref_mem[s][i]) + 256 * longint'(ref_mem[s][i+1]) +
                   65536 * longint'(ref_mem[s][i+2]) + 16777216 * longint'(ref_mem[s][i+3]);
    endcase
    return v[31:0];
  endfunction

  // Issue one request to DUT s (0: two wait states, 1: none) and report what came back
  task automatic run_access(input int s, input logic w, input logic [1:0] t, input logic sg,
                            input logic [31:0] a, input logic [31:0] d,
                            output int lat, output logic e, output logic [31:0] rd, output int busy);
    @(negedge clock);
    escrita = w; tamanho = t; sinal = sg; endereco = a; dado_escrita = d;
    if (s == 0) req_a = 1'b1; else req_b = 1'b1;
    lat = 0; busy = 0; e = 1'b0; rd = 32'd0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      req_a = 1'b0; req_b = 1'b0;
      if ((s == 0) ? pronto_a : pronto_b) begin
        lat = i;
        e   = (s == 0) ? erro_a : erro_b;
        rd  = (s == 0) ? lido_a : lido_b;
        break;
      end
      if ((s == 0) ? ocupado_a : ocupado_b) busy++;
    end
    if (model_valid(t, a)) begin
      if (w) begin
        for (int k = 0; k < (1 << t); k++) ref_mem[s][int'(a[9:0]) + k] = 8'(d >> (8 * k));
      end else begin
        last_rd[s] = model_load(s, t, sg, a);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; req_a = 1'b0; req_b = 1'b0;
    escrita = 1'b0; tamanho = 2'b00; sinal = 1'b0; endereco = 32'd0; dado_escrita = 32'd0;
    repeat (3) @(negedge clock);
    checks++; if ({ocupado_a, pronto_a, erro_a} !== 3'b000) begin errors++; $display("FAIL reset_ctrl_a got %b expected 000", {ocupado_a, pronto_a, erro_a}); end
    checks++; if (lido_a !== 32'd0) begin errors++; $display("FAIL reset_lido_a got %h expected 00000000", lido_a); end
    checks++; if ({ocupado_b, pronto_b, erro_b, lido_b} !== 35'd0) begin errors++; $display("FAIL reset_b got %h expected 0", {ocupado_b, pronto_b, erro_b, lido_b}); end
    reset = 1'b1;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    @(negedge clock);
  endtask

  task automatic test_store_load;
    int lat, busy; logic e; logic [31:0] rd;
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, e, rd, busy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d expected 3", lat); end
    checks++; if (busy !== 2) begin errors++; $display("FAIL store_ocupado_cycles got %0d expected 2", busy); end
    checks++; if (e !== 1'b0 || rd !== 32'd0) begin errors++; $display("FAIL store_outputs got erro=%b lido=%h expected erro=0 lido=00000000", e, rd); end
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd, busy);
    checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_word got %h expected deadbeef", rd); end
  endtask

  task automatic test_byte_lanes;
    int lat, busy; logic e; logic [31:0] rd;
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd, busy);
    run_access(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234567F, lat, e, rd, busy);
    run_access(0, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, e, rd, busy);
    checks++; if (rd !== 32'h0000007F) begin errors++; $display("FAIL load_byte_11 got %h expected 0000007f", rd); end
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, e, rd, busy);
    checks++; if (rd !== 32'h00007F00) begin errors++; $display("FAIL load_word_after_byte got %h expected 00007f00", rd); end
  endtask

  task automatic test_extension;
    int lat, busy; logic e; logic [31:0] rd;
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0000FF80, lat, e, rd, busy);
    run_access(0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, lat, e, rd, busy);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL half_signed got %h expected ffffff80", rd); end
    run_access(0, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, lat, e, rd, busy);
    checks++; if (rd !== 32'h0000FF80) begin errors++; $display("FAIL half_unsigned got %h expected 0000ff80", rd); end
    run_access(0, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0, lat, e, rd, busy);
    checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL byte_signed got %h expected ffffffff", rd); end
  endtask

  task automatic test_errors;
    int lat, busy; logic e; logic [31:0] rd;
    logic        ew [4];
    logic [1:0]  et [4];
    logic [31:0] ea [4];
    ew[0] = 1'b0; et[0] = 2'b10; ea[0] = 32'h22;
    ew[1] = 1'b0; et[1] = 2'b11; ea[1] = 32'h20;
    ew[2] = 1'b0; et[2] = 2'b10; ea[2] = 32'h400;
    ew[3] = 1'b1; et[3] = 2'b01; ea[3] = 32'h21;
    for (int i = 0; i < 4; i++) begin
      run_access(0, ew[i], et[i], 1'b0, ea[i], 32'hAAAA5555, lat, e, rd, busy);
      checks++; if (lat !== 1 || e !== 1'b1) begin errors++; $display("FAIL error_%0d got lat=%0d erro=%b expected lat=1 erro=1", i, lat, e); end
      checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL error_%0d_lido got %h expected ffffffff", i, rd); end
    end
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, rd, busy);
    checks++; if (rd !== 32'h0000FF80) begin errors++; $display("FAIL ram_after_errors got %h expected 0000ff80", rd); end
  endtask

  task automatic test_ignored_req;
    int n_pronto, first; logic [31:0] rd; int lat, busy; logic e;
    @(negedge clock);
    escrita = 1'b0; tamanho = 2'b10; sinal = 1'b0; endereco = 32'h10; req_a = 1'b1;
    n_pronto = 0; first = 0; rd = 32'd0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (pronto_a) begin n_pronto++; if (first == 0) begin first = i; rd = lido_a; end end
      if (i == 1) req_a = 1'b0;
      if (i == 2) begin escrita = 1'b1; tamanho = 2'b00; endereco = 32'h20; dado_escrita = 32'h55; req_a = 1'b1; end
      if (i == 4) req_a = 1'b0;
    end
    last_rd[0] = 32'h00007F00;
    checks++; if (n_pronto !== 1 || first !== 3) begin errors++; $display("FAIL ignored_req_pronto got count=%0d at=%0d expected count=1 at=3", n_pronto, first); end
    checks++; if (rd !== 32'h00007F00) begin errors++; $display("FAIL ignored_req_data got %h expected 00007f00", rd); end
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, lat, e, rd, busy);
    checks++; if (rd !== 32'h0000FF80) begin errors++; $display("FAIL ignored_store_leaked got %h expected 0000ff80", rd); end
  endtask

  task automatic test_reset_espera;
    int lat, busy, n_pronto; logic e; logic [31:0] rd;
    run_access(0, 1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344, lat, e, rd, busy);
    @(negedge clock);
    escrita = 1'b1; tamanho = 2'b10; endereco = 32'h30; dado_escrita = 32'hAAAAAAAA; req_a = 1'b1;
    @(negedge clock);
    req_a = 1'b0;
    checks++; if (ocupado_a !== 1'b1) begin errors++; $display("FAIL espera_ocupado got %b expected 1", ocupado_a); end
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if ({ocupado_a, pronto_a, erro_a, lido_a} !== 35'd0) begin errors++; $display("FAIL reset_in_espera got %h expected 0", {ocupado_a, pronto_a, erro_a, lido_a}); end
    @(negedge clock);
    reset = 1'b1;
    last_rd[0] = 32'd0; last_rd[1] = 32'd0;
    n_pronto = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clock); if (pronto_a || ocupado_a) n_pronto++; end
    checks++; if (n_pronto !== 0) begin errors++; $display("FAIL abort_activity got %0d expected 0", n_pronto); end
    run_access(0, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, lat, e, rd, busy);
    checks++; if (lat !== 3 || rd !== 32'h11223344) begin errors++; $display("FAIL aborted_store got lat=%0d lido=%h expected lat=3 lido=11223344", lat, rd); end
  endtask

  task automatic test_back_to_back;
    int lat, busy; logic e; logic [31:0] rd, d, a, exp;
    logic [1:0] t;
    run_access(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, lat, e, rd, busy);
    checks++; if (lat !== 1 || busy !== 0) begin errors++; $display("FAIL lat0_store got lat=%0d busy=%0d expected lat=1 busy=0", lat, busy); end
    for (int i = 0; i < 8; i++) begin
      t = 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 255)) & ~((32'd1 << t) - 32'd1);
      d = $urandom;
      run_access(1, 1'b1, t, 1'b0, a, d, lat, e, rd, busy);
      checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_store_%0d got lat=%0d expected 1", i, lat); end
      exp = model_load(1, t, i[0], a);
      run_access(1, 1'b0, t, i[0], a, 32'h0, lat, e, rd, busy);
      checks++; if (lat !== 1 || rd !== exp) begin errors++; $display("FAIL b2b_load_%0d got lat=%0d lido=%h expected lat=1 lido=%h", i, lat, rd, exp); end
    end
  endtask

  task automatic test_random;
    int lat, busy, r, exp_lat; logic e, w, sg, v; logic [1:0] t; logic [31:0] rd, a, d, exp_rd;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 16; k++) run_access(s, 1'b1, 2'b10, 1'b0, 32'(4 * k), $urandom, lat, e, rd, busy);
      for (int n = 0; n < 30; n++) begin
        w  = 1'($urandom_range(0, 1));
        sg = 1'($urandom_range(0, 1));
        r  = int'($urandom_range(0, 9));
        t  = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
        a  = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 9) < 8) a = a & ~((32'd1 << t) - 32'd1);
        if ($urandom_range(0, 9) == 0) a = $urandom | 32'h400;
        d  = $urandom;
        v  = model_valid(t, a);
        exp_lat = !v ? 1 : (s == 0) ? 3 : 1;
        exp_rd  = (v && !w) ? model_load(s, t, sg, a) : last_rd[s];
        run_access(s, w, t, sg, a, d, lat, e, rd, busy);
        checks++; if (lat !== exp_lat || e !== !v) begin errors++; $display("FAIL rand_%0d_%0d_handshake got lat=%0d erro=%b expected lat=%0d erro=%b", s, n, lat, e, exp_lat, !v); end
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand_%0d_%0d_lido got %h expected %h", s, n, rd, exp_rd); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_byte_lanes;
    test_extension;
    test_errors;
    test_ignored_req;
    test_reset_espera;
    test_back_to_back;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
